// File: rtl/trees_job_sequencer.sv
// trees_job_sequencer: host-side job splitter for trees_rtl_basic_dma64.
// Accepts one inference job (optional tree load plus N samples) and issues
// accelerator runs of at most MAX_BURST samples. It drives the conf strobe,
// waits for acc_done (bounded by a timeout) and advances the DMA feature index.
// Optional feature: define TREES_SEQ_PERF_EN to enable the busy-cycle counter.
module trees_job_sequencer #(
    parameter int unsigned N_FEATURE      = 32,
    parameter int unsigned MAX_BURST      = 5000,
    parameter int unsigned CONF_GAP       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic        job_load_trees,
    input  logic [31:0] job_n_samples,
    input  logic [31:0] job_feat_base,
    input  logic        job_abort,
    output logic        job_done,
    output logic        job_error,
    output logic        busy,
    output logic [31:0] samples_done,
    output logic        conf_info_load_trees,
    output logic [31:0] conf_info_burst_len,
    output logic [31:0] conf_feat_index,
    output logic        conf_done,
    input  logic        acc_done,
    output logic [31:0] perf_busy_cycles
);

    // Two fp32 features per 64-bit beat.
    localparam logic [31:0] BEATS_PER_SAMPLE = 32'(N_FEATURE / 2);
    localparam logic [31:0] BURST_MAX        = 32'(MAX_BURST);
    // A WAIT state lasts TIMEOUT_CYCLES-1 cycles, so the job_done cycle of a
    // timed-out run lands exactly TIMEOUT_CYCLES after its conf_done cycle.
    localparam logic [31:0] TO_LAST  = (TIMEOUT_CYCLES >= 2) ? 32'(TIMEOUT_CYCLES - 2) : 32'd0;
    localparam logic [31:0] GAP_LAST = (CONF_GAP >= 1) ? 32'(CONF_GAP - 1) : 32'd0;

    typedef enum logic [2:0] {
        IDLE, LOAD_CONF, LOAD_WAIT, RUN_CONF, RUN_WAIT, GAP, DONE
    } state_t;

    state_t      state;
    logic [31:0] rem;
    logic [31:0] idx;
    logic [31:0] burst;
    logic [31:0] tcnt;
    logic [31:0] gcnt;
    logic        abort_seen;

    logic        accept;
    logic        in_wait;
    logic        timed_out;
    logic        dec_go;
    logic        dec_done;
    logic [31:0] dec_rem;
    logic [31:0] dec_idx;
    logic [31:0] dec_burst;

    assign accept    = (state == IDLE) && job_valid && job_ready;
    assign in_wait   = (state == LOAD_WAIT) || (state == RUN_WAIT);
    assign timed_out = in_wait && !acc_done && (tcnt >= TO_LAST);

    // "What comes next" decision: finish the job or configure another run.
    // Remaining count and index are taken as they will be after this cycle,
    // so the same logic serves accept, GAP exit and a zero-length gap.
    always_comb begin
        dec_rem = rem;
        dec_idx = idx;
        if (state == IDLE) begin
            dec_rem = job_n_samples;
            dec_idx = job_feat_base;
        end else if (state == RUN_WAIT) begin
            dec_rem = rem - burst;
            dec_idx = idx + burst * BEATS_PER_SAMPLE;
        end
        dec_burst = (dec_rem > BURST_MAX) ? BURST_MAX : dec_rem;
        dec_done  = (dec_rem == 32'd0) ||
                    ((state != IDLE) && (abort_seen || job_abort));
        dec_go    = (accept && !job_load_trees) ||
                    ((state == GAP) && (gcnt == GAP_LAST)) ||
                    (in_wait && acc_done && (CONF_GAP == 0));
    end

    // Sequencer FSM with registered outputs; conf_done/job_done are set on
    // entry to the state they belong to, so they are high for exactly that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            job_ready            <= 1'b1;
            job_done             <= 1'b0;
            job_error            <= 1'b0;
            busy                 <= 1'b0;
            samples_done         <= '0;
            conf_info_load_trees <= 1'b0;
            conf_info_burst_len  <= '0;
            conf_feat_index      <= '0;
            conf_done            <= 1'b0;
            rem                  <= '0;
            idx                  <= '0;
            burst                <= '0;
            tcnt                 <= '0;
            gcnt                 <= '0;
            abort_seen           <= 1'b0;
        end else begin
            conf_done <= 1'b0;
            job_done  <= 1'b0;
            if ((state != IDLE) && job_abort)
                abort_seen <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        rem          <= job_n_samples;
                        idx          <= job_feat_base;
                        samples_done <= '0;
                        job_error    <= 1'b0;
                        abort_seen   <= 1'b0;
                        job_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (job_load_trees) begin
                            state                <= LOAD_CONF;
                            conf_done            <= 1'b1;
                            conf_info_load_trees <= 1'b1;
                            conf_info_burst_len  <= '0;
                            conf_feat_index      <= '0;
                        end
                    end
                end
                LOAD_CONF, RUN_CONF: begin
                    state <= (state == LOAD_CONF) ? LOAD_WAIT : RUN_WAIT;
                    tcnt  <= '0;
                end
                LOAD_WAIT, RUN_WAIT: begin
                    if (acc_done) begin
                        state <= GAP;
                        gcnt  <= '0;
                        if (state == RUN_WAIT) begin
                            rem          <= dec_rem;
                            idx          <= dec_idx;
                            samples_done <= samples_done + burst;
                        end
                    end else if (timed_out) begin
                        state     <= DONE;
                        job_done  <= 1'b1;
                        job_error <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                GAP: begin
                    gcnt <= gcnt + 32'd1;
                end
                DONE: begin
                    state     <= IDLE;
                    job_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Overrides the per-state next state when a decision is due.
            if (dec_go) begin
                if (dec_done) begin
                    state    <= DONE;
                    job_done <= 1'b1;
                end else begin
                    state                <= RUN_CONF;
                    conf_done            <= 1'b1;
                    conf_info_load_trees <= 1'b0;
                    conf_info_burst_len  <= dec_burst;
                    conf_feat_index      <= dec_idx;
                    burst                <= dec_burst;
                end
            end
        end
    end

`ifdef TREES_SEQ_PERF_EN
    logic [31:0] perf_cnt;

    // Busy-cycle counter: cleared on accept, saturating, held while idle.
    always_ff @(posedge clk) begin
        if (rst)
            perf_cnt <= '0;
        else if (accept)
            perf_cnt <= '0;
        else if (busy && (perf_cnt != 32'hFFFF_FFFF))
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_busy_cycles = perf_cnt;
`else
    assign perf_busy_cycles = '0;
`endif

endmodule

// File: tb/tb_trees_job_sequencer.sv
// Randomized self-checking bench for trees_job_sequencer. A job-level model
// lists the expected accelerator runs; the bench plays accelerator and
// checks every conf strobe, the job_done timing and the final counters.
module tb_trees_job_sequencer;

    localparam int NF   = 32;
    localparam int MAXB = 5000;
    localparam int GAP  = 2;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic        job_load_trees;
    logic [31:0] job_n_samples;
    logic [31:0] job_feat_base;
    logic        job_abort;
    logic        job_done;
    logic        job_error;
    logic        busy;
    logic [31:0] samples_done;
    logic        conf_info_load_trees;
    logic [31:0] conf_info_burst_len;
    logic [31:0] conf_feat_index;
    logic        conf_done;
    logic        acc_done;
    logic [31:0] perf_busy_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    trees_job_sequencer #(
        .N_FEATURE(NF), .MAX_BURST(MAXB), .CONF_GAP(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_load_trees(job_load_trees), .job_n_samples(job_n_samples),
        .job_feat_base(job_feat_base), .job_abort(job_abort),
        .job_done(job_done), .job_error(job_error), .busy(busy),
        .samples_done(samples_done),
        .conf_info_load_trees(conf_info_load_trees),
        .conf_info_burst_len(conf_info_burst_len),
        .conf_feat_index(conf_feat_index), .conf_done(conf_done),
        .acc_done(acc_done), .perf_busy_cycles(perf_busy_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One job end to end. abort_run / to_run: index of the run (tree load
    // counts as run 0) during which abort is raised / acc_done is withheld;
    // -1 disables. limit: deliver acc_done on the last cycle before timeout.
    task automatic run_job(input bit load, input logic [31:0] n, input logic [31:0] base,
                           input int abort_run, input int to_run, input bit limit);
        bit          ql[$];
        logic [31:0] qb[$];
        logic [31:0] qi[$];
        logic [31:0] rem, idx, b, exp_samples;
        bit          exp_err, finished, el;
        logic [31:0] eb, ei;
        int          cut, run_i, acc_at, exp_evt, k, done_cyc, last;

        // Reference: the run list follows directly from the job fields.
        rem = n;
        idx = base;
        if (load) begin ql.push_back(1'b1); qb.push_back(0); qi.push_back(0); end
        while (rem != 0) begin
            b = (rem > MAXB) ? MAXB : rem;
            ql.push_back(1'b0); qb.push_back(b); qi.push_back(idx);
            rem = rem - b;
            idx = idx + b * (NF / 2);
        end
        cut = (to_run >= 0) ? to_run : abort_run;
        if (cut >= 0)
            while (qb.size() > cut + 1) begin
                void'(ql.pop_back()); void'(qb.pop_back()); void'(qi.pop_back());
            end
        exp_err = (to_run >= 0) && !limit;
        exp_samples = 0;
        last = qb.size() - 1;
        for (int i = 0; i < qb.size(); i++)
            if (!ql[i] && !(exp_err && i == last))
                exp_samples += qb[i];

        @(negedge clk);
        chk("ready_before_accept", job_ready, 1);
        job_valid      = 1'b1;
        job_load_trees = load;
        job_n_samples  = n;
        job_feat_base  = base;
        k        = cyc;
        exp_evt  = k + 1;
        acc_at   = -1;
        run_i    = 0;
        finished = 0;
        done_cyc = 0;
        for (int t = 0; t < 2000 && !finished; t++) begin
            @(negedge clk);
            job_valid = 1'b0;
            acc_done  = 1'b0;
            if (conf_done) begin
                chk("conf_cycle", cyc, exp_evt);
                if (ql.size() == 0) begin
                    chk("conf_extra", 1, 0);
                end else begin
                    el = ql.pop_front(); eb = qb.pop_front(); ei = qi.pop_front();
                    chk("conf_load_trees", conf_info_load_trees, el);
                    chk("conf_burst_len", conf_info_burst_len, eb);
                    chk("conf_feat_index", conf_feat_index, ei);
                end
                if (run_i == to_run && !limit) begin
                    exp_evt = cyc + TO;
                end else begin
                    acc_at  = cyc + ((run_i == to_run) ? TO - 1 : int'($urandom_range(1, 6)));
                    exp_evt = -1;
                end
                if (run_i == abort_run) job_abort = 1'b1;
                run_i++;
            end
            if (job_done) begin
                chk("done_cycle", cyc, exp_evt);
                chk("done_error", job_error, exp_err);
                chk("done_samples", samples_done, exp_samples);
                chk("runs_missing", ql.size(), 0);
                finished = 1;
                done_cyc = cyc;
            end else begin
                chk("busy_not_ready", {job_ready, busy}, 2'b01);
            end
            if (acc_at == cyc) begin
                acc_done = 1'b1;
                exp_evt  = cyc + 1 + GAP;
                acc_at   = -1;
            end
        end
        if (!finished) chk("job_never_done", 0, 1);
        job_abort = 1'b0;
        acc_done  = 1'b0;
        @(negedge clk);
        chk("idle_after_done", {job_ready, busy, job_done, conf_done}, 4'b1000);
        chk("samples_held", samples_done, exp_samples);
`ifdef TREES_SEQ_PERF_EN
        chk("perf_busy", perf_busy_cycles, done_cyc - k);
`else
        chk("perf_tied", perf_busy_cycles, 0);
`endif
    endtask

    initial begin
        int          runs, ab;
        bit          ld, seen;
        logic [31:0] n;

        rst = 1'b1; job_valid = 1'b0; job_load_trees = 1'b0; job_n_samples = '0;
        job_feat_base = '0; job_abort = 1'b0; acc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {job_ready, job_done, job_error, busy, conf_done, conf_info_load_trees}, 6'b100000);
        chk("rst_samples", samples_done, 0);
        chk("rst_burst", conf_info_burst_len, 0);
        chk("rst_index", conf_feat_index, 0);
        chk("rst_perf", perf_busy_cycles, 0);
        rst = 1'b0;

        // Stray acc_done while idle must not start anything.
        @(negedge clk); acc_done = 1'b1;
        @(negedge clk); acc_done = 1'b0;
        chk("idle_stray_acc", {job_ready, busy, conf_done, job_done}, 4'b1000);

        run_job(1, 0, 32'h55, -1, -1, 0);             // tree load only
        run_job(0, 12000, 32'h100, -1, -1, 0);        // 5000/5000/2000
        run_job(0, 0, 32'h0, -1, -1, 0);              // empty job
        run_job(0, 3, 32'h10, -1, 0, 0);              // timeout
        run_job(0, 7, 32'h20, -1, 0, 1);              // acc_done on limit cycle
        run_job(0, 12000, 32'h0, 0, -1, 0);           // abort during run 1 of 3
        run_job(1, 100, 32'h0, 0, -1, 0);             // abort during tree load
        run_job(0, 10001, 32'hFFFF_FF00, -1, -1, 0);  // index wraps mod 2^32
        run_job(1, 5000, 32'h40, -1, 1, 0);           // timeout after tree load

        for (int j = 0; j < 25; j++) begin
            ld = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0: n = 0;
                1: n = $urandom_range(1, MAXB);
                2: n = MAXB * $urandom_range(1, 3);
                default: n = $urandom_range(1, 16000);
            endcase
            runs = int'(ld) + int'((n + MAXB - 1) / MAXB);
            ab = -1;
            if (runs > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, runs - 1);
            run_job(ld, n, $urandom, ab, -1, 0);
        end

        // Reset while a run is in flight drops the job silently.
        @(negedge clk);
        job_valid = 1'b1; job_load_trees = 1'b0; job_n_samples = 12000; job_feat_base = 32'h100;
        @(negedge clk);
        job_valid = 1'b0;
        seen = conf_done;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = conf_done;
        end
        chk("rst_test_conf_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midjob_rst_ctrl", {job_ready, job_done, job_error, busy, conf_done, conf_info_load_trees}, 6'b100000);
        chk("midjob_rst_samples", samples_done, 0);
        chk("midjob_rst_conf", conf_info_burst_len | conf_feat_index, 0);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        for (int t = 0; t < 4; t++) begin
            chk("post_rst_quiet", {job_ready, busy, conf_done, job_done}, 4'b1000);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
